// File: rtl/datapath_pkg.sv
// Shared encodings for the multi-cycle datapath: command/ALU opcodes, FSM states
// and the stack-pointer register index.
package datapath_pkg;

  typedef enum logic [2:0] {
    OP_ALU   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } cmd_op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_MOV = 3'd7
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM    = 2'd1,
    ST_RETIRE = 2'd2
  } state_e;

  // The top register doubles as the stack pointer.
  function automatic int unsigned sp_idx(input int unsigned reg_cnt);
    return reg_cnt - 1;
  endfunction

endpackage

// File: rtl/datapath_mc_reg_file_sp.sv
// Register file with two operand read ports, a debug read port, one general write
// port and a dedicated SP-update port; the SP register resets to all ones.
module reg_file_sp
  import datapath_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_CNT = 16,
  localparam int RA_W    = $clog2(REG_CNT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [RA_W-1:0]   ra_a_i,
  input  logic [RA_W-1:0]   ra_b_i,
  input  logic [RA_W-1:0]   ra_dbg_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  output logic [DATA_W-1:0] rd_dbg_o,
  output logic [DATA_W-1:0] sp_o,
  input  logic              we_i,
  input  logic [RA_W-1:0]   wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              sp_we_i,
  input  logic [DATA_W-1:0] sp_wd_i
);

  localparam int unsigned SP = sp_idx(REG_CNT);

  logic [DATA_W-1:0] regs_q [REG_CNT];

  // General write is issued last so it wins over an SP update to the same register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[SP] <= '1;
    end else begin
      if (sp_we_i) regs_q[SP] <= sp_wd_i;
      if (we_i)    regs_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o   = regs_q[ra_a_i];
  assign rd_b_o   = regs_q[ra_b_i];
  assign rd_dbg_o = regs_q[ra_dbg_i];
  assign sp_o     = regs_q[SP];

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle MiniRISC datapath: valid/ready command port, req/ack data-memory
// port with wait states, hardware PUSH/POP and a debug register write port.
module datapath_mc
  import datapath_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_CNT = 16,
  localparam int RA_W    = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        alu_sel,
  input  logic [RA_W-1:0]   reg_addr_x,
  input  logic [RA_W-1:0]   reg_addr_y,
  input  logic              op2_sel,
  input  logic [DATA_W-1:0] const_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  input  logic              mem_ack,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  output logic              flag_v,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] jump_address,
  input  logic              dbg_is_brk,
  input  logic              dbg_wr,
  input  logic [RA_W-1:0]   dbg_addr_in,
  input  logic [DATA_W-1:0] dbg_data_in,
  output logic [DATA_W-1:0] dbg_reg_dout
);

  localparam int MSB = DATA_W - 1;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [RA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
  logic              mem_we_q, mem_we_d;
  logic              flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic              flag_n_q, flag_n_d, flag_v_q, flag_v_d;

  logic [DATA_W-1:0] rx_val, ry_val, sp_val, op2;
  logic              rf_we, sp_we;
  logic [RA_W-1:0]   rf_wa;
  logic [DATA_W-1:0] rf_wd, sp_wd;

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   alu_ext;
  logic              alu_cin, alu_c, alu_v;

  reg_file_sp #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_rf (
    .clk_i    (clk),
    .rst_ni   (rst),
    .ra_a_i   (reg_addr_x),
    .ra_b_i   (reg_addr_y),
    .ra_dbg_i (dbg_addr_in),
    .rd_a_o   (rx_val),
    .rd_b_o   (ry_val),
    .rd_dbg_o (dbg_reg_dout),
    .sp_o     (sp_val),
    .we_i     (rf_we),
    .wa_i     (rf_wa),
    .wd_i     (rf_wd),
    .sp_we_i  (sp_we),
    .sp_wd_i  (sp_wd)
  );

  assign op2 = op2_sel ? ry_val : const_data;

  // Carry/borrow come from the extra top bit of a (DATA_W+1)-bit add/subtract.
  always_comb begin
    alu_ext = '0;
    alu_cin = 1'b0;
    alu_res = '0;
    alu_c   = flag_c_q;
    alu_v   = flag_v_q;
    unique case (alu_sel_e'(alu_sel))
      ALU_ADD, ALU_ADC: begin
        alu_cin = (alu_sel_e'(alu_sel) == ALU_ADC) & flag_c_q;
        alu_ext = {1'b0, rx_val} + {1'b0, op2} + {{DATA_W{1'b0}}, alu_cin};
        alu_res = alu_ext[MSB:0];
        alu_c   = alu_ext[DATA_W];
        alu_v   = (rx_val[MSB] == op2[MSB]) && (alu_res[MSB] != rx_val[MSB]);
      end
      ALU_SUB, ALU_SBC: begin
        alu_cin = (alu_sel_e'(alu_sel) == ALU_SBC) & flag_c_q;
        alu_ext = {1'b0, rx_val} - {1'b0, op2} - {{DATA_W{1'b0}}, alu_cin};
        alu_res = alu_ext[MSB:0];
        alu_c   = alu_ext[DATA_W];
        alu_v   = (rx_val[MSB] != op2[MSB]) && (alu_res[MSB] != rx_val[MSB]);
      end
      ALU_AND: alu_res = rx_val & op2;
      ALU_OR:  alu_res = rx_val | op2;
      ALU_XOR: alu_res = rx_val ^ op2;
      ALU_MOV: alu_res = op2;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rx_d       = rx_q;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    mem_we_d   = mem_we_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    flag_n_d   = flag_n_q;
    flag_v_d   = flag_v_q;
    rf_we      = 1'b0;
    rf_wa      = reg_addr_x;
    rf_wd      = alu_res;
    sp_we      = 1'b0;
    sp_wd      = sp_val;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          rx_d    = reg_addr_x;
          state_d = ST_RETIRE;
          case (cmd_op_e'(cmd_op))
            OP_ALU: begin
              rf_we    = 1'b1;
              flag_z_d = (alu_res == '0);
              flag_n_d = alu_res[MSB];
              flag_c_d = alu_c;
              flag_v_d = alu_v;
            end
            OP_LOAD: begin
              mem_addr_d = op2;
              mem_we_d   = 1'b0;
              state_d    = ST_MEM;
            end
            OP_STORE: begin
              mem_addr_d = op2;
              mem_we_d   = 1'b1;
              mem_dout_d = rx_val;
              state_d    = ST_MEM;
            end
            OP_PUSH: begin
              mem_addr_d = sp_val;
              mem_we_d   = 1'b1;
              mem_dout_d = rx_val;
              state_d    = ST_MEM;
            end
            OP_POP: begin
              mem_addr_d = sp_val + DATA_W'(1);
              mem_we_d   = 1'b0;
              state_d    = ST_MEM;
            end
            default: ;
          endcase
        end else if (dbg_wr && dbg_is_brk) begin
          rf_we = 1'b1;
          rf_wa = dbg_addr_in;
          rf_wd = dbg_data_in;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = ST_RETIRE;
          rf_wa   = rx_q;
          rf_wd   = mem_din;
          case (cmd_op_e'(op_q))
            OP_LOAD: rf_we = 1'b1;
            OP_PUSH: begin
              sp_we = 1'b1;
              sp_wd = sp_val - DATA_W'(1);
            end
            OP_POP: begin
              rf_we = 1'b1;
              sp_we = 1'b1;
              sp_wd = sp_val + DATA_W'(1);
            end
            default: ;
          endcase
        end
      end
      ST_RETIRE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rx_q       <= '0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      mem_we_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_v_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rx_q       <= rx_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      mem_we_q   <= mem_we_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      flag_n_q   <= flag_n_d;
      flag_v_q   <= flag_v_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE) && !dbg_is_brk;
  assign mem_req      = (state_q == ST_MEM);
  assign mem_we       = mem_we_q && mem_req;
  assign mem_addr     = mem_addr_q;
  assign mem_dout     = mem_dout_q;
  assign done         = (state_q == ST_RETIRE);
  assign flag_z       = flag_z_q;
  assign flag_c       = flag_c_q;
  assign flag_n       = flag_n_q;
  assign flag_v       = flag_v_q;
  assign sp           = sp_val;
  assign jump_address = op2;

endmodule

// File: tb/tb_datapath_mc.sv
// Randomised self-checking bench for datapath_mc against an arithmetic reference
// model of the register file, flags and stack pointer.
module tb_datapath_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, op2_sel;
  logic [2:0] cmd_op, alu_sel;
  logic [3:0] reg_addr_x, reg_addr_y, dbg_addr_in;
  logic [7:0] const_data, mem_addr, mem_dout, mem_din, sp, jump_address;
  logic [7:0] dbg_data_in, dbg_reg_dout;
  logic       mem_req, mem_we, mem_ack, done;
  logic       flag_z, flag_c, flag_n, flag_v;
  logic       dbg_is_brk, dbg_wr;

  always #10 clk = ~clk;

  datapath_mc #(.DATA_W(8), .REG_CNT(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .alu_sel(alu_sel), .reg_addr_x(reg_addr_x),
    .reg_addr_y(reg_addr_y), .op2_sel(op2_sel), .const_data(const_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack), .done(done),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
    .sp(sp), .jump_address(jump_address), .dbg_is_brk(dbg_is_brk),
    .dbg_wr(dbg_wr), .dbg_addr_in(dbg_addr_in), .dbg_data_in(dbg_data_in),
    .dbg_reg_dout(dbg_reg_dout)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] m_regs [16];
  logic       m_z, m_c, m_n, m_v;
  int         p_op, p_x, p_addr, p_dout;
  bit         p_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_regs[15] = 8'hFF;
    {m_z, m_c, m_n, m_v} = 4'b0000;
  endtask

  function automatic int to_signed(input int u);
    return (u > 127) ? u - 256 : u;
  endfunction

  task automatic alu_model(input int sel, input int x, input int a, input int b);
    int r, sr, ci;
    ci = m_c ? 1 : 0;
    case (sel)
      0, 1: begin
        if (sel == 0) ci = 0;
        r   = a + b + ci;
        sr  = to_signed(a) + to_signed(b) + ci;
        m_c = (r > 255);
        m_v = (sr > 127) || (sr < -128);
        r   = r % 256;
      end
      2, 3: begin
        if (sel == 2) ci = 0;
        r   = a - b - ci;
        sr  = to_signed(a) - to_signed(b) - ci;
        m_c = (r < 0);
        m_v = (sr > 127) || (sr < -128);
        r   = (r + 512) % 256;
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = b;
    endcase
    m_z = (r == 0);
    m_n = (r >= 128);
    m_regs[x] = 8'(r);
  endtask

  // Sweeps all registers through the debug read port within one idle cycle.
  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr_in = 4'(i);
      #1;
      chk($sformatf("%s_R%0d", tag, i), dbg_reg_dout, m_regs[i]);
    end
    chk({tag, "_sp"}, sp, m_regs[15]);
    chk({tag, "_flags"}, {flag_z, flag_c, flag_n, flag_v}, {m_z, m_c, m_n, m_v});
  endtask

  task automatic check_mem_phase(input string tag);
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_addr"}, mem_addr, p_addr);
    chk({tag, "_we"}, mem_we, p_we);
    if (p_we) chk({tag, "_dout"}, mem_dout, p_dout);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic start_cmd(input int op, input int sel, input int x, input int y,
                           input bit o2, input int k);
    int n, op2;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_op = 3'(op); alu_sel = 3'(sel); reg_addr_x = 4'(x); reg_addr_y = 4'(y);
    op2_sel = o2; const_data = 8'(k); cmd_valid = 1'b1;
    op2 = o2 ? int'(m_regs[y]) : k;
    #1;
    chk("jump_address", jump_address, op2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    p_op = op; p_x = x; p_we = 1'b0; p_dout = 0; p_addr = 0;
    case (op)
      0: begin
        alu_model(sel, x, int'(m_regs[x]), op2);
        chk("alu_done", done, 1);
      end
      1: p_addr = op2;
      2: begin p_addr = op2; p_we = 1'b1; p_dout = int'(m_regs[x]); end
      3: begin p_addr = int'(m_regs[15]); p_we = 1'b1; p_dout = int'(m_regs[x]); end
      4: p_addr = (int'(m_regs[15]) + 1) % 256;
      default: chk("rsv_done", done, 1);
    endcase
    if (op >= 1 && op <= 4) check_mem_phase("accept");
    chk("busy_after_accept", cmd_ready, 0);
  endtask

  task automatic finish_mem(input int waitc, input logic [7:0] din);
    for (int w = 0; w < waitc; w++) begin
      @(posedge clk); #1;
      check_mem_phase("wait");
      chk("wait_ready", cmd_ready, 0);
    end
    mem_ack = 1'b1; mem_din = din;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    case (p_op)
      1: m_regs[p_x] = din;
      3: m_regs[15] = m_regs[15] - 8'd1;
      4: begin m_regs[15] = m_regs[15] + 8'd1; m_regs[p_x] = din; end
      default: ;
    endcase
    chk("ack_req_drop", mem_req, 0);
    chk("ack_done", done, 1);
  endtask

  task automatic finish_retire();
    @(posedge clk); #1;
    chk("retire_done_low", done, 0);
    chk("retire_ready", cmd_ready, !dbg_is_brk);
  endtask

  task automatic run_cmd(input int op, input int sel, input int x, input int y,
                         input bit o2, input int k, input int waitc, input int din);
    start_cmd(op, sel, x, y, o2, k);
    if (op >= 1 && op <= 4) finish_mem(waitc, 8'(din));
    finish_retire();
    check_regs("cmd");
  endtask

  task automatic dbg_write(input int a, input int d);
    dbg_is_brk = 1'b1; dbg_wr = 1'b1; dbg_addr_in = 4'(a); dbg_data_in = 8'(d);
    @(posedge clk); #1;
    dbg_wr = 1'b0;
    m_regs[a] = 8'(d);
    chk("dbg_readback", dbg_reg_dout, d);
    chk("brk_ready", cmd_ready, 0);
    dbg_is_brk = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; alu_sel = '0; reg_addr_x = '0;
    reg_addr_y = '0; op2_sel = 1'b0; const_data = '0; mem_din = '0; mem_ack = 1'b0;
    dbg_is_brk = 1'b0; dbg_wr = 1'b0; dbg_addr_in = '0; dbg_data_in = '0;
    model_reset();
    #15;
    chk("rst_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", cmd_ready, 1);
    check_regs("reset");

    // ADD overflow into the sign bit
    dbg_write(1, 8'h7F);
    run_cmd(0, 0, 1, 0, 1'b0, 8'h01, 0, 0);
    dbg_addr_in = 4'd1; #1;
    chk("add_r1", dbg_reg_dout, 8'h80);
    chk("add_nvcz", {flag_n, flag_v, flag_c, flag_z}, 4'b1100);

    // SUB with borrow, then SBC consuming it
    dbg_write(3, 8'h01);
    run_cmd(0, 2, 2, 3, 1'b1, 0, 0, 0);
    chk("sub_c", flag_c, 1);
    dbg_write(4, 8'h05);
    run_cmd(0, 3, 4, 0, 1'b0, 8'h01, 0, 0);
    dbg_addr_in = 4'd4; #1;
    chk("sbc_r4", dbg_reg_dout, 8'h03);

    // PUSH with three wait states, then POP
    run_cmd(3, 0, 1, 0, 1'b0, 0, 3, 0);
    chk("push_sp", sp, 8'hFE);
    run_cmd(4, 0, 5, 0, 1'b0, 0, 1, 8'h3C);
    chk("pop_sp", sp, 8'hFF);

    // SP wrap and POP into SP
    dbg_write(15, 8'h00);
    run_cmd(3, 0, 2, 0, 1'b0, 0, 0, 0);
    chk("wrap_sp", sp, 8'hFF);
    run_cmd(4, 0, 15, 0, 1'b0, 0, 2, 8'h42);
    chk("pop_into_sp", sp, 8'h42);

    // dbg_wr without breakpoint is ignored
    dbg_wr = 1'b1; dbg_addr_in = 4'd2; dbg_data_in = 8'h11;
    @(posedge clk); #1;
    dbg_wr = 1'b0;
    check_regs("dbg_ignored");

    // Asynchronous reset while waiting in MEM
    start_cmd(1, 0, 6, 0, 1'b0, 8'h20);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_sp", sp, 8'hFF);
    chk("mid_rst_flags", {flag_z, flag_c, flag_n, flag_v}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", cmd_ready, 1);
    check_regs("mid_rst");

    // Breakpoint raised during a LOAD wait: LOAD completes, then commands stall
    start_cmd(1, 0, 6, 0, 1'b0, 8'h30);
    @(posedge clk); #1;
    dbg_is_brk = 1'b1;
    finish_mem(0, 8'h5A);
    finish_retire();
    @(posedge clk); #1;
    chk("brk_stall", cmd_ready, 0);
    dbg_write(7, 8'hA5);
    @(posedge clk); #1;
    check_regs("brk");

    // Randomised command stream
    for (int n = 0; n < 300; n++) begin
      int r, op;
      r  = $urandom_range(0, 11);
      op = (r < 8) ? r : r - 8;
      if ($urandom_range(0, 9) == 0) dbg_write($urandom_range(0, 15), $urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        mem_ack = 1'b1; mem_din = 8'($urandom);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("idle_ack_req", mem_req, 0);
      end
      run_cmd(op, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
              1'($urandom), $urandom_range(0, 255), $urandom_range(0, 3),
              $urandom_range(0, 255));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_mc.md
Name: datapath_mc

Overview:
- Parametrised, multi-cycle successor to the MiniRISC datapath.
- Executes one command at a time from the control unit over a valid/ready handshake.
- Talks to data memory over a req/ack handshake, so memory may insert wait states.
- Adds hardware PUSH/POP with automatic stack-pointer update, plus a debug register write port.
- Sits between the control unit and the data-memory bus arbiter.

Parameters:
- DATA_W, 8, data and register width; the memory address width equals DATA_W.
- REG_CNT, 16, number of registers (power of two, >=4); register REG_CNT-1 is SP.
- RA_W, $clog2(REG_CNT), register address width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  datapath can accept a command.
- cmd_op  in  3  0 ALU, 1 LOAD, 2 STORE, 3 PUSH, 4 POP; 5-7 reserved.
- alu_sel  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 MOV.
- reg_addr_x  in  RA_W  destination / first operand / store source.
- reg_addr_y  in  RA_W  second operand / indirect address.
- op2_sel  in  1  0 const_data, 1 register Y.
- const_data  in  DATA_W  immediate or absolute address.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, valid while mem_req=1.
- mem_addr  out  DATA_W  memory address.
- mem_dout  out  DATA_W  write data.
- mem_din  in  DATA_W  read data, valid when mem_ack=1.
- mem_ack  in  1  transfer complete.
- done  out  1  one-cycle pulse when a command retires.
- flag_z, flag_c, flag_n, flag_v  out  1 each  registered ALU flags.
- sp  out  DATA_W  current SP value.
- jump_address  out  DATA_W  operand-2 value, combinational.
- dbg_is_brk  in  1  breakpoint state.
- dbg_wr  in  1  debug register write.
- dbg_addr_in  in  RA_W  debug register address.
- dbg_data_in  in  DATA_W  debug write data.
- dbg_reg_dout  out  DATA_W  register selected by dbg_addr_in, combinational.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All registers clear to 0, except SP, which is set to all ones.
  - Flags clear to 0.
  - mem_req, mem_we and done go to 0 immediately.
  - mem_addr and mem_dout go to 0.
- FSM states: IDLE, MEM, RETIRE.
- cmd_ready=1 only when the state is IDLE and dbg_is_brk=0.
- Commands are accepted on a rising edge with cmd_valid and cmd_ready both high.
- op2 = op2_sel ? Ry : const_data.
- ALU command:
  - Result is written to Rx and flags update on the accept edge; state goes to RETIRE.
  - done pulses for one cycle in RETIRE, then the state returns to IDLE.
  - Latency is 2 cycles, accept to ready.
- Flag rules:
  - Z and N are always taken from the result.
  - C: carry out for ADD/ADC; borrow (1 when unsigned Rx < op2 (+C)) for SUB/SBC.
  - V: two's-complement overflow for arithmetic ops.
  - Logic ops and MOV leave C and V unchanged.
  - ADC/SBC use the flag C value registered before the command.
- Memory commands: on accept, latch the operands and enter MEM with mem_req=1.
  - LOAD: mem_addr=op2, mem_we=0.
  - STORE: mem_addr=op2, mem_we=1, mem_dout=Rx.
  - PUSH: mem_addr=SP, mem_we=1, mem_dout=Rx.
  - POP: mem_addr=SP+1 (modulo 2^DATA_W), mem_we=0.
- MEM state:
  - mem_addr, mem_we and mem_dout stay stable until the edge on which mem_ack=1; unbounded wait states are allowed.
  - On the ack edge, LOAD and POP write mem_din to Rx.
  - On the ack edge, PUSH sets SP to SP-1 and POP sets SP to SP+1.
  - mem_req drops and the state goes to RETIRE; minimum latency is 3 cycles.
  - mem_ack outside MEM is ignored.
- SP wrap-around: SP wraps modulo 2^DATA_W with no error indication (0x00-1 becomes 0xFF).
- POP with Rx=SP: the loaded data wins and the increment is discarded.
- PUSH of SP: the pre-decrement value is stored.
- ALU writes to SP are permitted.
- Debug access:
  - When dbg_is_brk=1 in IDLE, no commands are accepted.
  - dbg_wr=1 writes dbg_data_in to the register at dbg_addr_in on that edge.
  - dbg_wr is ignored when dbg_is_brk=0 or the state is not IDLE.
- dbg_is_brk asserting during MEM or RETIRE: the in-flight command completes first.
- Reserved cmd_op values: treated as no-operation; the command retires through RETIRE with no state change.

Decomposition:
- Shared package datapath_pkg holds:
  - cmd_op and alu_sel encodings;
  - the FSM state encoding;
  - the SP index function (REG_CNT-1).
- One sub-module, reg_file_sp, holds the parametrised register file:
  - async-low reset with SP reset to all ones;
  - two combinational read ports plus a debug read port;
  - one write port, plus a separate SP-update port with write-port priority.
- The ALU stays inline as combinational logic.

Test Plan:
- ALU ADD: R1=0x7F, const 0x01, op2_sel=0 -> R1=0x80, N=1, V=1, C=0, Z=0; done pulses 1 cycle after accept.
- SUB: R2=0x00, Ry=R3=0x01 -> R2=0xFF, C=1, N=1; then SBC R4=0x05, const 0x01 -> R4=0x03.
- PUSH R1 after reset -> mem_addr=0xFF, mem_we=1, mem_dout=R1; mem_ack delayed 3 cycles keeps mem_req and the address stable and cmd_ready=0; afterwards SP=0xFE. POP R5 -> mem_addr=0xFF, R5=mem_din, SP=0xFF.
- SP wrap: debug-write SP=0x00, then PUSH -> SP=0xFF; POP with Rx=SP returns mem_din into SP.
- rst=0 asserted while in MEM -> mem_req=0 in the same cycle, SP=0xFF, flags 0, and after release cmd_ready=1.
- dbg_is_brk=1 raised during a LOAD wait -> the LOAD completes, then cmd_ready stays 0; dbg_wr to R7=0xA5 gives dbg_reg_dout=0xA5.
